pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Drives the enable/flush controls of the PC and the D/E/M/W stage registers.
- Handles load-use stalls, taken-branch flushes, data-memory wait states with a timeout, and halt/drain/resume requests from the debug interface.
- Sits beside the datapath; every stage register takes its enable/flush from this block.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before forced abort.
- DRAIN_CYCLES, 4: bubble cycles issued in DRAIN before entering HALTED.
- TO_W, 5: width of the wait/drain counter; must satisfy 2^TO_W > max(MEM_TIMEOUT, DRAIN_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1_addr  in  5  D-stage source register 1.
- id_rs2_addr  in  5  D-stage source register 2.
- ex_rd_addr  in  5  E-stage destination register.
- ex_mem_read  in  1  E-stage instruction is a load.
- ex_branch_taken  in  1  E-stage branch/jump resolved taken.
- dm_req  in  1  M-stage data-memory access active.
- dm_ack  in  1  data memory completes the access this cycle.
- halt_req  in  1  level request to halt the core.
- resume  in  1  one-cycle pulse that leaves HALTED.
- pc_en  out  1  PC update enable.
- reg_d_en, reg_e_en, reg_m_en  out  1 each  stage register hold (0 = hold).
- reg_d_flush, reg_e_flush, reg_w_flush  out  1 each  load a bubble (all zeros) next edge.
- halted  out  1  core halted.
- mem_err  out  1  one-cycle pulse on data-memory timeout.

Behaviour:
- Registered state: state ∈ {RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3}, cnt[TO_W-1:0], mem_err.
- Control outputs are combinational from state and inputs.
- Reset: rst=1 at an edge sets state=RUN, cnt=0, mem_err=0.
- While rst is high, all *_en=0, all *_flush=0 and halted=0, regardless of state.
- Reset mid-wait or mid-drain aborts immediately with no pulse.
- Default in RUN: all en=1, all flush=0.
- RUN priority (highest first):
  - 1) dm_req && !dm_ack: pc/d/e/m en=0, reg_w_flush=1; next state MEM_WAIT, cnt=1.
  - 2) ex_branch_taken: reg_d_flush=1, reg_e_flush=1, pc_en=1. The PC loads the target; the datapath muxes it.
  - 3) Load-use: ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr). Then pc_en=0, reg_d_en=0, reg_e_flush=1; a 1-cycle bubble.
  - 4) halt_req: pc_en=0, reg_d_flush=1; next state DRAIN, cnt=1.
  - Branch and load-use never both act; branch wins.
  - halt_req is ignored in a cycle where 1) applies and is re-evaluated after returning to RUN.
- MEM_WAIT:
  - pc/d/e/m en=0, reg_w_flush=1.
  - If dm_ack: behave exactly as RUN with items 2–4 (all en=1 unless they override); next state RUN.
  - Else if cnt==MEM_TIMEOUT: mem_err=1 next cycle; the M-stage access is discarded via reg_w_flush this cycle; next state RUN.
  - Else cnt++.
- DRAIN:
  - pc_en=0, reg_d_flush=1; downstream stages run normally so in-flight instructions retire.
  - A stalled memory access in DRAIN behaves as in MEM_WAIT but stays in DRAIN and freezes cnt.
  - When cnt==DRAIN_CYCLES and no wait: next state HALTED. Else cnt++.
- HALTED:
  - halted=1; all en=0; flushes=0.
  - resume=1: next state RUN, cnt=0.
  - resume while halt_req is still high: RUN for one cycle, then re-enters DRAIN.
- mem_err: registered, high for exactly one cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined: adds outputs stall_cycles[31:0] and flush_events[31:0]. Both reset to 0 and wrap at 2^32.
  - stall_cycles increments every cycle pc_en=0 while state is RUN or MEM_WAIT.
  - flush_events increments once per cycle reg_e_flush=1.
- When not defined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle -> pc_en=0, reg_d_en=0, reg_e_flush=1 that cycle only; next cycle (ex_mem_read=0) all en=1.
- Branch vs load-use: ex_branch_taken=1 plus a load-use match -> reg_d_flush=reg_e_flush=1, pc_en=1, reg_d_en=1.
- Memory wait: dm_req=1, dm_ack=0 for 3 cycles, ack on the 4th -> 3 cycles pc_en=0 / reg_w_flush=1, state back to RUN after the ack edge, mem_err=0.
- Timeout: dm_req=1, dm_ack never -> mem_err pulses once 17 cycles after the stall starts (MEM_TIMEOUT=16); state then RUN.
- Halt: halt_req=1 -> 4 DRAIN cycles with pc_en=0, then halted=1; resume pulse with halt_req=0 -> halted=0 and pc_en=1 next cycle.
- Reset mid-MEM_WAIT: rst=1 at cycle 2 of a wait -> next cycle state=RUN, no mem_err; with PIPE_CTRL_PERF_EN both counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage core.
// Drives PC/D/E/M enables and D/E/W flushes.
//
// Ports (all 1 bit unless noted):
//   clk, rst             clock, sync active-high reset
//   id_rs1/rs2_addr [5]  D-stage sources
//   ex_rd_addr [5]       E-stage destination
//   ex_mem_read          E-stage load
//   ex_branch_taken      E-stage taken branch/jump
//   dm_req, dm_ack       M-stage memory request/complete
//   halt_req, resume     debug halt level / resume pulse
//   pc_en, reg_*_en      enables (0 = hold)
//   reg_*_flush          load a bubble next edge
//   halted, mem_err      halted flag, timeout pulse
// Macro PIPE_CTRL_PERF_EN adds stall_cycles and
// flush_events [32] counters.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TO_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       dm_req,
  input  logic       dm_ack,
  input  logic       halt_req,
  input  logic       resume,
  output logic       pc_en,
  output logic       reg_d_en,
  output logic       reg_e_en,
  output logic       reg_m_en,
  output logic       reg_d_flush,
  output logic       reg_e_flush,
  output logic       reg_w_flush,
  output logic       halted,
  output logic       mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] DR_MAX = TO_W'(DRAIN_CYCLES);
  localparam logic [TO_W-1:0] ONE    = TO_W'(1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;

  logic stall, load_use;
  logic r_pc, r_d_en, r_d_fl, r_e_fl, r_halt;

  assign stall    = dm_req & ~dm_ack;
  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((ex_rd_addr == id_rs1_addr) ||
                     (ex_rd_addr == id_rs2_addr));

  // Branch / load-use / halt priority, shared by RUN and
  // the ack cycle of MEM_WAIT.
  always_comb begin
    r_pc   = 1'b1;
    r_d_en = 1'b1;
    r_d_fl = 1'b0;
    r_e_fl = 1'b0;
    r_halt = 1'b0;
    if (ex_branch_taken) begin
      r_d_fl = 1'b1;
      r_e_fl = 1'b1;
    end else if (load_use) begin
      r_pc   = 1'b0;
      r_d_en = 1'b0;
      r_e_fl = 1'b1;
    end else if (halt_req) begin
      r_pc   = 1'b0;
      r_d_fl = 1'b1;
      r_halt = 1'b1;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    reg_d_en    = 1'b1;
    reg_e_en    = 1'b1;
    reg_m_en    = 1'b1;
    reg_d_flush = 1'b0;
    reg_e_flush = 1'b0;
    reg_w_flush = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_err_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (stall) begin
          pc_en       = 1'b0;
          reg_d_en    = 1'b0;
          reg_e_en    = 1'b0;
          reg_m_en    = 1'b0;
          reg_w_flush = 1'b1;
          state_d     = MEM_WAIT;
          cnt_d       = ONE;
        end else begin
          pc_en       = r_pc;
          reg_d_en    = r_d_en;
          reg_d_flush = r_d_fl;
          reg_e_flush = r_e_fl;
          if (r_halt) begin
            state_d = DRAIN;
            cnt_d   = ONE;
          end
        end
      end
      MEM_WAIT: begin
        if (dm_ack) begin
          pc_en       = r_pc;
          reg_d_en    = r_d_en;
          reg_d_flush = r_d_fl;
          reg_e_flush = r_e_fl;
          state_d     = RUN;
          cnt_d       = '0;
        end else begin
          pc_en       = 1'b0;
          reg_d_en    = 1'b0;
          reg_e_en    = 1'b0;
          reg_m_en    = 1'b0;
          reg_w_flush = 1'b1;
          if (cnt_q == TO_MAX) begin
            mem_err_d = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      DRAIN: begin
        if (stall) begin
          // Hold everything; drain count resumes after ack.
          pc_en       = 1'b0;
          reg_d_en    = 1'b0;
          reg_e_en    = 1'b0;
          reg_m_en    = 1'b0;
          reg_w_flush = 1'b1;
        end else begin
          pc_en       = 1'b0;
          reg_d_flush = 1'b1;
          if (cnt_q == DR_MAX) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      HALTED: begin
        pc_en    = 1'b0;
        reg_d_en = 1'b0;
        reg_e_en = 1'b0;
        reg_m_en = 1'b0;
        halted   = 1'b1;
        if (resume) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
    endcase

    if (rst) begin
      pc_en       = 1'b0;
      reg_d_en    = 1'b0;
      reg_e_en    = 1'b0;
      reg_m_en    = 1'b0;
      reg_d_flush = 1'b0;
      reg_e_flush = 1'b0;
      reg_w_flush = 1'b0;
      halted      = 1'b0;
      state_d     = RUN;
      cnt_d       = '0;
      mem_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (state_q == RUN || state_q == MEM_WAIT))
        stall_q <= stall_q + 32'd1;
      if (reg_e_flush)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized scoreboard bench for pipe_ctrl.
// Driver pushes model outputs; monitor pops at negedge.
module tb_pipe_ctrl;
  localparam int TO = 16;
  localparam int DR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       ex_mem_read, ex_branch_taken;
  logic       dm_req, dm_ack, halt_req, resume;
  logic       pc_en, reg_d_en, reg_e_en, reg_m_en;
  logic       reg_d_flush, reg_e_flush, reg_w_flush;
  logic       halted, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipe_ctrl #(
    .MEM_TIMEOUT(TO), .DRAIN_CYCLES(DR), .TO_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .dm_req(dm_req), .dm_ack(dm_ack),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .reg_d_en(reg_d_en),
    .reg_e_en(reg_e_en), .reg_m_en(reg_m_en),
    .reg_d_flush(reg_d_flush), .reg_e_flush(reg_e_flush),
    .reg_w_flush(reg_w_flush),
    .halted(halted), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  // {pc,d_en,e_en,m_en,d_fl,e_fl,w_fl,halted,mem_err}
  typedef struct {
    logic [8:0]  v;
    logic [31:0] sc;
    logic [31:0] fe;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: mode 0 run, 1 waiting on memory,
  // 2 draining, 3 halted; plain counters for wait/drain.
  int          m_mode = 0;
  int          m_waited = 0;
  int          m_drained = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  task automatic hazard_rules(output bit pc, output bit de,
                              output bit df, output bit ef,
                              output bit go_halt);
    bit lu;
    lu = ex_mem_read && ex_rd_addr != 0 &&
         (ex_rd_addr == id_rs1_addr ||
          ex_rd_addr == id_rs2_addr);
    pc = 1; de = 1; df = 0; ef = 0; go_halt = 0;
    if (ex_branch_taken) begin
      df = 1; ef = 1;
    end else if (lu) begin
      pc = 0; de = 0; ef = 1;
    end else if (halt_req) begin
      pc = 0; df = 1; go_halt = 1;
    end
  endtask

  task automatic model_step(output exp_t e);
    bit pc, de, ee, me, df, ef, wf, h, gh, err_n, stl;
    int mode_now;
    pc = 1; de = 1; ee = 1; me = 1;
    df = 0; ef = 0; wf = 0; h = 0; err_n = 0;
    stl = dm_req && !dm_ack;
    mode_now = m_mode;
    e.sc = m_stall;
    e.fe = m_flush;
    e.cyc = cyc;
    if (rst) begin
      {pc, de, ee, me, df, ef, wf, h} = '0;
      m_mode = 0; m_waited = 0; m_drained = 0;
    end else begin
      case (m_mode)
        0: begin
          if (stl) begin
            {pc, de, ee, me} = '0; wf = 1;
            m_mode = 1; m_waited = 1;
          end else begin
            hazard_rules(pc, de, df, ef, gh);
            if (gh) begin
              m_mode = 2; m_drained = 1;
            end
          end
        end
        1: begin
          if (dm_ack) begin
            hazard_rules(pc, de, df, ef, gh);
            m_mode = 0;
          end else begin
            {pc, de, ee, me} = '0; wf = 1;
            if (m_waited == TO) begin
              err_n = 1; m_mode = 0;
            end else m_waited++;
          end
        end
        2: begin
          if (stl) begin
            {pc, de, ee, me} = '0; wf = 1;
          end else begin
            pc = 0; df = 1;
            if (m_drained == DR) m_mode = 3;
            else m_drained++;
          end
        end
        default: begin
          {pc, de, ee, me} = '0; h = 1;
          if (resume) m_mode = 0;
        end
      endcase
    end
    e.v = {pc, de, ee, me, df, ef, wf, h, m_err};
    if (rst) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (!pc && (mode_now == 0 || mode_now == 1))
        m_stall = m_stall + 32'd1;
      if (ef) m_flush = m_flush + 32'd1;
    end
    m_err = err_n;
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pc_en, reg_d_en, reg_e_en, reg_m_en,
               reg_d_flush, reg_e_flush, reg_w_flush,
               halted, mem_err};
        n_tests++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL ctrl cyc %0d: got %b expected %b",
                   e.cyc, got, e.v);
        end
`ifdef PIPE_CTRL_PERF_EN
        n_tests++;
        if (stall_cycles !== e.sc || flush_events !== e.fe) begin
          n_fail++;
          $display("FAIL perf cyc %0d: got %0d/%0d expected %0d/%0d",
                   e.cyc, stall_cycles, flush_events, e.sc, e.fe);
        end
`endif
      end
    end
  end

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Driver
  initial begin
    exp_t e;
    int kind, p_req, p_ack, p_halt, p_res, waitc;
    rst = 1; id_rs1_addr = 0; id_rs2_addr = 0;
    ex_rd_addr = 0; ex_mem_read = 0; ex_branch_taken = 0;
    dm_req = 0; dm_ack = 0; halt_req = 0; resume = 0;
    repeat (2) @(posedge clk);
    for (int ep = 0; ep < 80; ep++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin p_req = 20; p_ack = 60; p_halt = 3;  p_res = 30; end
        1: begin p_req = 90; p_ack = 0;  p_halt = 5;  p_res = 30; end
        2: begin p_req = 5;  p_ack = 70; p_halt = 90; p_res = 20; end
        default: begin
          p_req = 60; p_ack = 10; p_halt = 30; p_res = 40;
        end
      endcase
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        cyc++;
        rst = (ep == 0 && c == 0) ? 1'b0 : pct(1);
        id_rs1_addr = 5'($urandom_range(0, 3));
        id_rs2_addr = 5'($urandom_range(0, 3));
        ex_rd_addr = 5'($urandom_range(0, 3));
        ex_mem_read = pct(40);
        ex_branch_taken = pct(20);
        dm_req = pct(p_req);
        dm_ack = pct(p_ack);
        halt_req = pct(p_halt);
        resume = pct(p_res);
        model_step(e);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    rst = 1;
    waitc = 0;
    while (exp_q.size() > 0 && waitc < 5) begin
      @(posedge clk);
      waitc++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
